// File: rtl/apb_2_axi_lite.sv
// apb_2_axi_lite
// Bridges one APB slave port onto an AXI-lite master port. Each APB access
// phase is turned into one AXI-lite write or read, and the APB transfer is
// held in wait states until the AXI response comes back.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESETN : sole clock, synchronous active-low reset
//   P*                        : APB slave (PREADY/PRDATA/PSLVERR returned)
//   M_AXI_AW*/W*/B*           : AXI-lite write address, data, response
//   M_AXI_AR*/R*              : AXI-lite read address, data
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for an APB access phase
// WR_REQ   | AW and W offered; each valid drops on its own handshake
// WR_RESP  | BREADY high, waiting for the write response
// RD_REQ   | ARVALID high, waiting for ARREADY
// RD_RESP  | RREADY high, waiting for read data
// DONE     | PREADY high for one cycle with PRDATA/PSLVERR
module apb_2_axi_lite #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 5
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,

    input  logic [AXI_ADDR_WIDTH-1:0]     PADDR,
    input  logic [2:0]                    PPROT,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [AXI_DATA_WIDTH-1:0]     PWDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]   PSTRB,
    output logic                          PREADY,
    output logic [AXI_DATA_WIDTH-1:0]     PRDATA,
    output logic                          PSLVERR,

    output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,

    output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_RESP = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    logic [2:0]                  state;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]                  prot_q;
    logic [AXI_DATA_WIDTH-1:0]   data_q;
    logic [AXI_DATA_WIDTH/8-1:0] strb_q;
    logic                        done_q;
    logic                        aw_ok;
    logic                        w_ok;

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_AWPROT = prot_q;
    assign M_AXI_ARPROT = prot_q;
    assign M_AXI_WDATA  = data_q;
    assign M_AXI_WSTRB  = strb_q;

    // A channel is finished when it already handshook earlier (valid low)
    // or is handshaking in this cycle.
    always_comb begin
        aw_ok = !M_AXI_AWVALID || M_AXI_AWREADY;
        w_ok  = !M_AXI_WVALID  || M_AXI_WREADY;
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state         <= ST_IDLE;
            addr_q        <= '0;
            prot_q        <= '0;
            data_q        <= '0;
            strb_q        <= '0;
            done_q        <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            PREADY        <= 1'b0;
            PSLVERR       <= 1'b0;
            PRDATA        <= '0;
        end else begin
            // The cycle right after DONE still carries the finished transfer's
            // PSEL/PENABLE if the master has not moved on; never restart on it.
            done_q <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (PSEL && PENABLE && !done_q) begin
                        addr_q <= PADDR;
                        prot_q <= PPROT;
                        data_q <= PWDATA;
                        strb_q <= PSTRB;
                        if (PWRITE) begin
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= ST_WR_REQ;
                        end else begin
                            M_AXI_ARVALID <= 1'b1;
                            state         <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        PREADY       <= 1'b1;
                        PSLVERR      <= M_AXI_BRESP[1];
                        PRDATA       <= '0;
                        state        <= ST_DONE;
                    end
                end
                ST_RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        PREADY       <= 1'b1;
                        PSLVERR      <= M_AXI_RRESP[1];
                        PRDATA       <= M_AXI_RDATA;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_2_axi_lite.sv
// Bench for apb_2_axi_lite: APB master tasks push the expected PRDATA/PSLVERR
// into a queue; the entry is popped and compared when PREADY is seen. A
// behavioural AXI-lite memory slave with programmable delays answers the DUT.
module tb_apb_2_axi_lite;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]   paddr = '0;
    logic [2:0]      pprot = '0;
    logic            psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [DW-1:0]   pwdata = '0;
    logic [DW/8-1:0] pstrb = '0;
    logic            pready, pslverr;
    logic [DW-1:0]   prdata;

    logic [AW-1:0]   awaddr, araddr;
    logic [2:0]      awprot, arprot;
    logic            awvalid, wvalid, bready, arvalid, rready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic            arready = 1'b0, rvalid = 1'b0;
    logic [1:0]      bresp = '0, rresp = '0;
    logic [DW-1:0]   rdata = '0;

    apb_2_axi_lite #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .PADDR(paddr), .PPROT(pprot), .PSEL(psel), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;
    exp_t sb[$];

    // slave configuration
    int         aw_dly = 0, w_dly = 0, ar_dly = 0, rsp_dly = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [DW-1:0] mem [8];

    // slave state and statistics
    int  aw_cnt = 0, w_cnt = 0, ar_cnt = 0, rsp_cnt = 0;
    bit  aw_have = 0, w_have = 0, ar_have = 0, b_fire = 0, r_fire = 0;
    bit  aw_pend = 0, w_pend = 0, ar_pend = 0;
    logic [AW-1:0]   got_awaddr = '0, got_araddr = '0, pend_awaddr = '0, pend_araddr = '0;
    logic [DW-1:0]   got_wdata = '0, pend_wdata = '0;
    logic [DW/8-1:0] got_wstrb = '0, pend_wstrb = '0;
    int  aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int  awv_cyc = 0, wv_cyc = 0, pr_cyc = 0, overlap = 0, unstable = 0;
    int  n_done = 0;

    always @(negedge clk) begin
        if (pready) pr_cyc++;
        if ((awvalid || wvalid || bready) && (arvalid || rready)) overlap++;
        if (awvalid) awv_cyc++;
        if (wvalid)  wv_cyc++;
        if (!rst_n) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_have = 0; w_have = 0; ar_have = 0; b_fire = 0; r_fire = 0;
            aw_pend = 0; w_pend = 0; ar_pend = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; rsp_cnt = 0;
        end else begin
            if (aw_pend && (!awvalid || awaddr !== pend_awaddr)) unstable++;
            if (w_pend && (!wvalid || wdata !== pend_wdata || wstrb !== pend_wstrb)) unstable++;
            if (ar_pend && (!arvalid || araddr !== pend_araddr)) unstable++;

            // write response, issued the cycle after both beats have landed
            if (b_fire) begin
                bvalid = 0; b_fire = 0; aw_have = 0; w_have = 0;
            end else if (aw_have && w_have && !bvalid) begin
                if (rsp_cnt >= rsp_dly) begin
                    for (int b = 0; b < DW / 8; b++)
                        if (got_wstrb[b]) mem[got_awaddr[4:2]][8*b +: 8] = got_wdata[8*b +: 8];
                    bvalid = 1; bresp = bresp_cfg; rsp_cnt = 0;
                end else rsp_cnt++;
            end
            if (bvalid && bready) begin b_fire = 1; b_hs++; end

            // read data
            if (r_fire) begin
                rvalid = 0; r_fire = 0; ar_have = 0;
            end else if (ar_have && !rvalid) begin
                if (rsp_cnt >= rsp_dly) begin
                    rvalid = 1; rresp = rresp_cfg; rdata = mem[got_araddr[4:2]]; rsp_cnt = 0;
                end else rsp_cnt++;
            end
            if (rvalid && rready) begin r_fire = 1; r_hs++; end

            awready = 0;
            if (awvalid && !aw_have) begin
                if (aw_cnt >= aw_dly) begin
                    awready = 1; aw_have = 1; aw_hs++; got_awaddr = awaddr; aw_cnt = 0;
                end else aw_cnt++;
            end
            wready = 0;
            if (wvalid && !w_have) begin
                if (w_cnt >= w_dly) begin
                    wready = 1; w_have = 1; w_hs++; got_wdata = wdata; got_wstrb = wstrb; w_cnt = 0;
                end else w_cnt++;
            end
            arready = 0;
            if (arvalid && !ar_have) begin
                if (ar_cnt >= ar_dly) begin
                    arready = 1; ar_have = 1; ar_hs++; got_araddr = araddr; ar_cnt = 0;
                end else ar_cnt++;
            end

            aw_pend = awvalid && !awready; pend_awaddr = awaddr;
            w_pend  = wvalid && !wready;   pend_wdata = wdata; pend_wstrb = wstrb;
            ar_pend = arvalid && !arready; pend_araddr = araddr;
        end
    end

    task automatic clr_stats();
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; awv_cyc = 0; wv_cyc = 0;
    endtask

    task automatic apb_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW/8-1:0] s, input logic [DW-1:0] exp_rd,
                            input logic exp_err, input string tag, output int lat);
        exp_t e;
        int cyc;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        @(negedge clk);
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; pprot = 3'b010;
        @(negedge clk);
        penable = 1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (pready !== 1'b1 && cyc < 60);
        lat = cyc;
        e = sb.pop_front();
        if (pready !== 1'b1) begin
            chk({tag, "_timeout"}, 64'(pready), 64'd1);
        end else begin
            n_done++;
            chk({tag, "_prdata"}, 64'(prdata), 64'(e.rdata));
            chk({tag, "_pslverr"}, 64'(pslverr), 64'(e.err));
        end
        @(posedge clk);
        #1;
        psel = 0; penable = 0;
    endtask

    int lat, seen, pr_before;

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_pready",  64'(pready),  64'd0);
        chk("rst_pslverr", 64'(pslverr), 64'd0);
        chk("rst_prdata",  64'(prdata),  64'd0);
        chk("rst_valids",  64'({awvalid, wvalid, arvalid}), 64'd0);
        chk("rst_readies", 64'({bready, rready}), 64'd0);
        chk("rst_addr_data", 64'({awaddr, wdata, wstrb}), 64'd0);
        rst_n = 1;

        // setup phase alone must not launch anything
        @(negedge clk);
        psel = 1; penable = 0; pwrite = 1; paddr = 5'h10;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (awvalid || wvalid || arvalid) seen++;
        end
        chk("setup_only_no_axi", 64'(seen), 64'd0);
        psel = 0;

        // zero-wait write
        clr_stats();
        apb_xfer(1, 5'h04, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "wr0", lat);
        chk("wr0_awaddr", 64'(got_awaddr), 64'h04);
        chk("wr0_wdata",  64'(got_wdata),  64'hDEADBEEF);
        chk("wr0_wstrb",  64'(got_wstrb),  64'hF);
        chk("wr0_beats",  64'({8'(aw_hs), 8'(w_hs), 8'(b_hs)}), 64'h010101);
        chk("wr0_latency", 64'(lat), 64'd3);
        chk("wr0_mem",    64'(mem[1]), 64'hDEADBEEF);

        // AWREADY late, WREADY immediate, SLVERR response
        clr_stats();
        aw_dly = 3; bresp_cfg = 2'b10;
        apb_xfer(1, 5'h0C, 32'hA5A50001, 4'hF, 32'h0, 1'b1, "wr_awlate", lat);
        chk("wr_awlate_wv_cyc",  64'(wv_cyc),  64'd1);
        chk("wr_awlate_awv_cyc", 64'(awv_cyc), 64'd4);
        chk("wr_awlate_b_hs",    64'(b_hs),    64'd1);
        aw_dly = 0;
        bresp_cfg = 2'b11;
        apb_xfer(1, 5'h0C, 32'hA5A50002, 4'hF, 32'h0, 1'b1, "wr_decerr", lat);
        bresp_cfg = 2'b01;
        w_dly = 2;
        apb_xfer(1, 5'h0C, 32'hA5A50003, 4'hF, 32'h0, 1'b0, "wr_exokay_wlate", lat);
        w_dly = 0; bresp_cfg = 2'b00;

        // read with two response wait cycles, then every RRESP code
        mem[2] = 32'h12345678;
        rsp_dly = 2;
        clr_stats();
        rresp_cfg = 2'b10;
        apb_xfer(0, 5'h08, '0, '0, 32'h12345678, 1'b1, "rd_slverr", lat);
        chk("rd_araddr", 64'(got_araddr), 64'h08);
        chk("rd_beats",  64'({8'(ar_hs), 8'(r_hs)}), 64'h0101);
        rsp_dly = 0;
        for (int r = 0; r < 4; r++) begin
            logic [1:0] code;
            code = 2'(r);
            rresp_cfg = code;
            apb_xfer(0, 5'h08, '0, '0, 32'h12345678, code[1], $sformatf("rd_rresp%0d", r), lat);
        end
        rresp_cfg = 2'b00;

        // reset while ARVALID waits for ARREADY
        ar_dly = 1000;
        @(negedge clk);
        psel = 1; penable = 0; pwrite = 0; paddr = 5'h0C;
        @(negedge clk);
        penable = 1;
        repeat (3) @(negedge clk);
        chk("abort_arvalid_before", 64'(arvalid), 64'd1);
        rst_n = 0; psel = 0; penable = 0;
        @(negedge clk);
        chk("abort_arvalid_after", 64'(arvalid), 64'd0);
        chk("abort_pready_after",  64'(pready),  64'd0);
        rst_n = 1;
        @(posedge clk); #1;
        pr_before = pr_cyc;
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        chk("abort_no_pready", 64'(pr_cyc), 64'(pr_before));
        ar_dly = 0;
        mem[3] = 32'hCAFE0003;
        apb_xfer(0, 5'h0C, '0, '0, 32'hCAFE0003, 1'b0, "rd_after_abort", lat);

        // partial strobe, then a read-back
        mem[4] = 32'h0;
        apb_xfer(1, 5'h10, 32'hFFFFFFFF, 4'b0011, 32'h0, 1'b0, "wr_strb", lat);
        apb_xfer(0, 5'h10, '0, '0, 32'h0000FFFF, 1'b0, "rd_strb", lat);

        // eight writes then eight reads, random slave timing
        for (int i = 0; i < 8; i++) begin
            aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2);
            rsp_dly = $urandom_range(0, 2);
            apb_xfer(1, 5'(4 * i), 32'(i), 4'hF, 32'h0, 1'b0, $sformatf("seq_wr%0d", i), lat);
        end
        for (int i = 0; i < 8; i++) begin
            ar_dly = $urandom_range(0, 2); rsp_dly = $urandom_range(0, 2);
            apb_xfer(0, 5'(4 * i), '0, '0, 32'(i), 1'b0, $sformatf("seq_rd%0d", i), lat);
        end

        repeat (3) @(negedge clk);
        chk("no_overlap",      64'(overlap),  64'd0);
        chk("valid_stability", 64'(unstable), 64'd0);
        chk("pready_one_cycle_each", 64'(pr_cyc), 64'(n_done));
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
